biquad_scheduler: RTL and testbench
===================================

Name: biquad_scheduler

Overview:
- Stereo sequencer for a second-order (biquad) lowpass section; processes left and right through one time-multiplexed multiply-accumulate datapath.
- Accepts one L/R sample pair per strobe and steps the shared multiplier through five taps per channel.
- Owns per-channel history, the coefficient ROM and filter-select latching; returns a saturated stereo pair with a valid pulse.
- Sits between the audio codec sample interface and the downstream channel-strip stages.

Parameters:
- W, 64, internal accumulator/product/history width in bits (signed).
- SHIFT, 30, coefficient fractional bits (coefficient = real value × 2^SHIFT).

Ports:
- clk_144  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- filter  in  3  filter select: 0 allpass, 1 = 1 kHz, 2 = 2.5 kHz, 3 = 5 kHz, 4 = 10 kHz, 5-7 allpass.
- in_valid  in  1  one-cycle strobe; in_left/in_right are valid.
- in_left  in  16  signed left input sample.
- in_right  in  16  signed right input sample.
- ovr_clr  in  1  clears overrun when high.
- busy  out  1  high whenever state ≠ IDLE.
- out_valid  out  1  one-cycle pulse; out_left/out_right are updated.
- out_left  out  16  signed left result, held until next update.
- out_right  out  16  signed right result, held until next update.
- overrun  out  1  sticky; a strobe was dropped.

Behaviour:
- Reset (async, high): all outputs 0; history x1, x2, y1, y2 per channel 0; active_sel 0; state IDLE.
- Reset mid-operation: in-flight pair is abandoned and no out_valid is produced.
- Coefficient ROM (b0, b1, b2, a1, a2), as real values scaled by 2^SHIFT:
  - sel0: 1, 0, 0, 0, 0
  - sel1: 0.00390625, 0.0078125, 0.00390625, 1.8125, -0.828125
  - sel2: 0.021728515625, 0.04345703125, 0.021728515625, 1.546875, -0.625
  - sel3: 0.072265625, 0.14453125, 0.072265625, 1.109375, -0.390625
  - sel4: 0.220703125, 0.44140625, 0.220703125, 0.3125, -0.1875
- Difference equation: y = b0·x0 + b1·x1 + b2·x2 + a1·y1 + a2·y2.
- Arithmetic: each product is formed at W bits and arithmetic-shifted right by SHIFT individually, then accumulated at W bits.
- Saturation: acc > 32767 → 32767; acc < -32767 → -32767; otherwise acc[15:0].
- History update: x1/x2 hold input samples sign-extended to W. y1/y2 hold the saturated output.
- FSM states: IDLE, MAC_L (taps 0-4), UPD_L, MAC_R (taps 0-4), UPD_R, DONE.
  - IDLE: edge k with in_valid=1 latches both samples and filter into active_sel; accumulator cleared; → MAC_L tap0.
  - Filter change: if the latched filter ≠ previous active_sel, all history of both channels is zeroed before tap0 uses it (flush, prevents instability).
  - MAC_L: one product per cycle, tap order b0·x0, b1·x1, b2·x2, a1·y1, a2·y2; after tap4 (edge k+5) → UPD_L.
  - UPD_L: latch saturated left into out_left shadow; x2←x1, x1←x0, y2←y1, y1←y; clear accumulator; → MAC_R.
  - MAC_R, UPD_R: identical for right; edge k+11 → UPD_R, edge k+12 → DONE.
  - DONE: out_left/out_right both updated together; out_valid=1 for exactly this cycle; → IDLE.
- Latency: out_valid is high in the cycle after edge k+12. Minimum accept interval is 13 clocks.
- in_valid while busy (including during DONE): ignored and overrun←1.
- overrun clears only on ovr_clr=1 or reset. If ovr_clr and a drop occur in the same cycle, set wins.
- filter changes mid-operation have no effect until the next accepted strobe.
- out_left/out_right never change except in DONE.

Test Plan:
- Allpass: filter=0, pair (1000, -1000) → out_valid exactly 12 edges after accept, outputs (1000, -1000); busy high 13 cycles.
- Impulse, filter=1, zero history: pair (16384, 16384) → (64, 64). Next pair (0, 0) → (244, 244).
- Saturation, filter=0: (-32768, 32767) → (-32767, 32767). Filter=4, repeated pair (32767, 32767) → settles at and holds 32767 on both outputs.
- Flush: run filter=1 with (16384, 0) then (0, 0), switch to filter=2, send (0, 0) → (0, 0). History cleared; filter=2 impulse then matches the fresh-state response.
- Overrun: strobe at accept+3 and at the DONE cycle → both dropped, overrun=1, only one out_valid. ovr_clr pulse → overrun=0.
- Reset mid-op: assert reset at accept+6 → out_valid never fires, outputs 0, busy 0. Next allpass pair (5, 7) → (5, 7).

Source files
------------

// File: rtl/biquad_scheduler.sv
// Stereo biquad lowpass sequencer: one shared multiplier steps five taps for left,
// then right, and presents both saturated results together with a one-cycle valid.
module biquad_scheduler #(
    parameter int W     = 64,
    parameter int SHIFT = 30
) (
    input  logic               clk_144,
    input  logic               reset,
    input  logic [2:0]         filter,
    input  logic               in_valid,
    input  logic signed [15:0] in_left,
    input  logic signed [15:0] in_right,
    input  logic               ovr_clr,
    output logic               busy,
    output logic               out_valid,
    output logic signed [15:0] out_left,
    output logic signed [15:0] out_right,
    output logic               overrun
);
    typedef enum logic [2:0] {IDLE, MAC_L, UPD_L, MAC_R, UPD_R, DONE} state_t;

    localparam logic signed [W-1:0] POS_LIM = 32767;
    localparam logic signed [W-1:0] NEG_LIM = -32767;

    state_t               state;
    logic [2:0]           tap;
    logic [2:0]           active_sel;
    logic signed [15:0]   x0_l, x0_r, sh_left;
    logic signed [W-1:0]  acc;
    logic signed [W-1:0]  x1 [2];
    logic signed [W-1:0]  x2 [2];
    logic signed [W-1:0]  y1 [2];
    logic signed [W-1:0]  y2 [2];

    logic                 ch;
    logic signed [15:0]   xs, y_sat;
    logic signed [W-1:0]  coef, opnd, prod, acc_sum;

    // num / 2^fb expressed with SHIFT fractional bits
    function automatic logic signed [W-1:0] cq(input int num, input int fb);
        logic signed [W-1:0] v;
        v = W'(num);
        return v <<< (SHIFT - fb);
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [W-1:0] a);
        if (a > POS_LIM)      return 16'sd32767;
        else if (a < NEG_LIM) return -16'sd32767;
        else                  return a[15:0];
    endfunction

    always_comb begin
        coef = '0;
        case (active_sel)
            3'd1: case (tap)
                3'd0, 3'd2: coef = cq(1, 8);
                3'd1:       coef = cq(1, 7);
                3'd3:       coef = cq(29, 4);
                3'd4:       coef = cq(-53, 6);
                default:    coef = '0;
            endcase
            3'd2: case (tap)
                3'd0, 3'd2: coef = cq(89, 12);
                3'd1:       coef = cq(89, 11);
                3'd3:       coef = cq(99, 6);
                3'd4:       coef = cq(-5, 3);
                default:    coef = '0;
            endcase
            3'd3: case (tap)
                3'd0, 3'd2: coef = cq(37, 9);
                3'd1:       coef = cq(37, 8);
                3'd3:       coef = cq(71, 6);
                3'd4:       coef = cq(-25, 6);
                default:    coef = '0;
            endcase
            3'd4: case (tap)
                3'd0, 3'd2: coef = cq(113, 9);
                3'd1:       coef = cq(113, 8);
                3'd3:       coef = cq(5, 4);
                3'd4:       coef = cq(-3, 4);
                default:    coef = '0;
            endcase
            default: if (tap == 3'd0) coef = cq(1, 0);
        endcase
    end

    assign ch = (state == MAC_R) || (state == UPD_R);

    always_comb begin
        xs = ch ? x0_r : x0_l;
        case (tap)
            3'd0:    opnd = W'(xs);
            3'd1:    opnd = x1[ch];
            3'd2:    opnd = x2[ch];
            3'd3:    opnd = y1[ch];
            3'd4:    opnd = y2[ch];
            default: opnd = '0;
        endcase
    end

    assign prod    = coef * opnd;
    assign acc_sum = acc + (prod >>> SHIFT);
    assign y_sat   = sat16(acc);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk_144 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tap        <= '0;
            active_sel <= '0;
            x0_l       <= '0;
            x0_r       <= '0;
            sh_left    <= '0;
            acc        <= '0;
            out_valid  <= 1'b0;
            out_left   <= '0;
            out_right  <= '0;
            overrun    <= 1'b0;
            for (int c = 0; c < 2; c++) begin
                x1[c] <= '0; x2[c] <= '0; y1[c] <= '0; y2[c] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            // a drop in the same cycle as ovr_clr keeps the flag set
            if (ovr_clr) overrun <= 1'b0;
            if (in_valid && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: if (in_valid) begin
                    x0_l       <= in_left;
                    x0_r       <= in_right;
                    active_sel <= filter;
                    acc        <= '0;
                    tap        <= '0;
                    state      <= MAC_L;
                    // new coefficients on old history can ring or blow up
                    if (filter != active_sel)
                        for (int c = 0; c < 2; c++) begin
                            x1[c] <= '0; x2[c] <= '0; y1[c] <= '0; y2[c] <= '0;
                        end
                end
                MAC_L, MAC_R: begin
                    acc <= acc_sum;
                    if (tap == 3'd4) begin
                        tap   <= '0;
                        state <= (state == MAC_L) ? UPD_L : UPD_R;
                    end else begin
                        tap <= tap + 3'd1;
                    end
                end
                UPD_L, UPD_R: begin
                    x2[ch] <= x1[ch];
                    x1[ch] <= W'(xs);
                    y2[ch] <= y1[ch];
                    y1[ch] <= W'(y_sat);
                    acc    <= '0;
                    if (state == UPD_L) begin
                        sh_left <= y_sat;
                        state   <= MAC_R;
                    end else begin
                        out_left  <= sh_left;
                        out_right <= y_sat;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_biquad_scheduler.sv
// Directed bench for biquad_scheduler: allpass, impulse, saturation, flush, overrun, reset.
module tb_biquad_scheduler;
    logic               clk_144 = 1'b0;
    logic               reset;
    logic [2:0]         filter;
    logic               in_valid, ovr_clr;
    logic signed [15:0] in_left, in_right;
    logic               busy, out_valid, overrun;
    logic signed [15:0] out_left, out_right;

    int total = 0;
    int bad   = 0;
    int lat, bc;
    logic signed [15:0] ol, orr;

    biquad_scheduler dut (
        .clk_144(clk_144), .reset(reset), .filter(filter), .in_valid(in_valid),
        .in_left(in_left), .in_right(in_right), .ovr_clr(ovr_clr), .busy(busy),
        .out_valid(out_valid), .out_left(out_left), .out_right(out_right), .overrun(overrun)
    );

    always #5 clk_144 = ~clk_144;

    // one strobe, then watch 30 cycles; lat = cycles from accept edge to out_valid
    task automatic run_pair(input logic signed [15:0] l, input logic signed [15:0] r,
                            input logic [2:0] f, output int lt, output int bcnt,
                            output logic signed [15:0] vl, output logic signed [15:0] vr);
        @(negedge clk_144);
        in_left = l; in_right = r; filter = f; in_valid = 1'b1;
        @(negedge clk_144);
        in_valid = 1'b0;
        lt = -1; bcnt = 0; vl = 'x; vr = 'x;
        for (int n = 0; n < 30; n++) begin
            if (busy) bcnt++;
            if (out_valid && lt < 0) begin lt = n; vl = out_left; vr = out_right; end
            @(negedge clk_144);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; ovr_clr = 1'b0; filter = '0; in_left = '0; in_right = '0;
        repeat (3) @(negedge clk_144);
        total++;
        if ({busy, out_valid, overrun, out_left, out_right} !== 35'd0) begin
            bad++; $display("FAIL reset_held got=%h exp=0", {busy, out_valid, overrun, out_left, out_right});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk_144);
        total++;
        if ({busy, out_valid, overrun, out_left, out_right} !== 35'd0) begin
            bad++; $display("FAIL reset_released got=%h exp=0", {busy, out_valid, overrun, out_left, out_right});
        end
    endtask

    task automatic test_allpass();
        run_pair(1000, -1000, 3'd0, lat, bc, ol, orr);
        total++;
        if (lat !== 12) begin bad++; $display("FAIL allpass_latency got=%0d exp=12", lat); end
        total++;
        if (bc !== 13) begin bad++; $display("FAIL allpass_busy got=%0d exp=13", bc); end
        total++;
        if ({ol, orr} !== {16'sd1000, -16'sd1000}) begin
            bad++; $display("FAIL allpass_out got=%0d,%0d exp=1000,-1000", ol, orr);
        end
    endtask

    task automatic test_impulse();
        logic signed [15:0] exp_y [3] = '{16'sd64, 16'sd244, 16'sd453};
        logic signed [15:0] in_x  [3] = '{16'sd16384, 16'sd0, 16'sd0};
        for (int i = 0; i < 3; i++) begin
            run_pair(in_x[i], in_x[i], 3'd1, lat, bc, ol, orr);
            total++;
            if ({ol, orr} !== {exp_y[i], exp_y[i]}) begin
                bad++; $display("FAIL impulse_%0d got=%0d,%0d exp=%0d,%0d", i, ol, orr, exp_y[i], exp_y[i]);
            end
        end
    endtask

    task automatic test_saturation();
        run_pair(-32768, 32767, 3'd0, lat, bc, ol, orr);
        total++;
        if ({ol, orr} !== {-16'sd32767, 16'sd32767}) begin
            bad++; $display("FAIL sat_allpass got=%0d,%0d exp=-32767,32767", ol, orr);
        end
        for (int i = 0; i < 8; i++) begin
            run_pair(32767, 32767, 3'd4, lat, bc, ol, orr);
            if (i == 0) begin
                total++;
                if ({ol, orr} !== {16'sd7231, 16'sd7231}) begin
                    bad++; $display("FAIL sat_first got=%0d,%0d exp=7231,7231", ol, orr);
                end
            end else if (i >= 4) begin
                total++;
                if ({ol, orr} !== {16'sd32767, 16'sd32767}) begin
                    bad++; $display("FAIL sat_hold_%0d got=%0d,%0d exp=32767,32767", i, ol, orr);
                end
            end
        end
    endtask

    task automatic test_flush();
        logic signed [15:0] xl [4] = '{16'sd16384, 16'sd0, 16'sd0, 16'sd16384};
        logic signed [15:0] xr [4] = '{16'sd0, 16'sd0, 16'sd0, 16'sd16384};
        logic [2:0]         fs [4] = '{3'd1, 3'd1, 3'd2, 3'd2};
        logic signed [15:0] el [4] = '{16'sd64, 16'sd244, 16'sd0, 16'sd356};
        logic signed [15:0] er [4] = '{16'sd0, 16'sd0, 16'sd0, 16'sd356};
        for (int i = 0; i < 4; i++) begin
            run_pair(xl[i], xr[i], fs[i], lat, bc, ol, orr);
            total++;
            if ({ol, orr} !== {el[i], er[i]}) begin
                bad++; $display("FAIL flush_%0d got=%0d,%0d exp=%0d,%0d", i, ol, orr, el[i], er[i]);
            end
        end
    endtask

    task automatic test_overrun();
        int pulses = 0;
        @(negedge clk_144);
        in_left = 11; in_right = 22; filter = 3'd0; in_valid = 1'b1;
        @(negedge clk_144);
        in_valid = 1'b0; in_left = 999; in_right = 999;
        for (int t = 1; t <= 30; t++) begin
            in_valid = (t == 3) || (t == 13);
            ovr_clr  = (t == 5) || (t == 13);
            @(negedge clk_144);
            if (out_valid) pulses++;
            if (t == 3) begin
                total++;
                if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_mac_drop got=%b exp=1", overrun); end
                total++;
                if (out_left !== 16'sd356) begin bad++; $display("FAIL ovr_out_held got=%0d exp=356", out_left); end
            end
            if (t == 5) begin
                total++;
                if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
            end
            if (t == 13) begin
                total++;
                if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_done_set_wins got=%b exp=1", overrun); end
            end
        end
        in_valid = 1'b0; ovr_clr = 1'b0;
        total++;
        if (pulses !== 1) begin bad++; $display("FAIL ovr_pulses got=%0d exp=1", pulses); end
        total++;
        if ({out_left, out_right, busy} !== {16'sd11, 16'sd22, 1'b0}) begin
            bad++; $display("FAIL ovr_out got=%0d,%0d busy=%b exp=11,22 busy=0", out_left, out_right, busy);
        end
        ovr_clr = 1'b1;
        @(negedge clk_144);
        ovr_clr = 1'b0;
        total++;
        if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_final_clear got=%b exp=0", overrun); end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        @(negedge clk_144);
        in_left = 300; in_right = 400; filter = 3'd0; in_valid = 1'b1;
        @(negedge clk_144);
        in_valid = 1'b0;
        repeat (5) @(negedge clk_144);
        reset = 1'b1;
        @(negedge clk_144);
        reset = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (out_valid) pulses++;
            @(negedge clk_144);
        end
        total++;
        if (pulses !== 0) begin bad++; $display("FAIL rstmid_pulses got=%0d exp=0", pulses); end
        total++;
        if ({out_left, out_right, busy, overrun} !== 34'd0) begin
            bad++; $display("FAIL rstmid_state got=%0d,%0d busy=%b ovr=%b exp=0,0,0,0", out_left, out_right, busy, overrun);
        end
        run_pair(5, 7, 3'd0, lat, bc, ol, orr);
        total++;
        if ({lat, ol, orr} !== {32'sd12, 16'sd5, 16'sd7}) begin
            bad++; $display("FAIL rstmid_next got=lat%0d %0d,%0d exp=lat12 5,7", lat, ol, orr);
        end
    endtask

    initial begin
        test_reset();
        test_allpass();
        test_impulse();
        test_saturation();
        test_flush();
        test_overrun();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
